// File: rtl/chip_link_tx_pkg.sv
// Shared definitions for the inter-chip link: sizing helpers, serialiser state
// encoding and phit field widths used by both link directions.
package chip_link_tx_pkg;

  localparam int LINK_PW      = 16;
  localparam int LINK_VALID_W = 1;
  localparam int LINK_SOW_W   = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Phits per word: the last phit is zero-padded when DW is not a multiple of PW.
  function automatic int nphit(input int dw, input int pw);
    return (dw + pw - 1) / pw;
  endfunction

  function automatic int phit_cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/link_send_fifo.sv
// Synchronous send FIFO with occupancy count; pushes into a full FIFO are dropped.
module link_send_fifo #(
  parameter int DW         = 60,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_pop,
  output logic [DW-1:0]         o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign w_push_ok = i_push & (r_count != FULL_CNT);
  assign w_pop_ok  = i_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/chip_link_tx.sv
// Transmit side of the inter-chip link: buffers tagged words and serialises
// them LSB-phit first onto a narrow valid/ready link.
module chip_link_tx
  import chip_link_tx_pkg::*;
#(
  parameter int DW         = 60,
  parameter int PW         = LINK_PW,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_out_wr,
  input  logic [DW-1:0]       data_out,
  output logic                send_fifo_full,
  output logic                link_valid,
  output logic [PW-1:0]       link_data,
  output logic                link_sow,
  input  logic                link_ready,
  output logic                overflow_err,
  output logic                tx_idle,
  output tx_state_e           o_dbg_state,
  output logic [DEPTH_LOG2:0] o_dbg_count
);

  localparam int NPHIT = nphit(DW, PW);
  localparam int PCW   = phit_cnt_w(NPHIT);
  localparam int SW    = NPHIT * PW;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [PCW-1:0]      LAST_PHIT = PCW'(NPHIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_THR  = CW'(DEPTH - 2);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = CW'(DEPTH);

  tx_state_e           r_state;
  logic [SW-1:0]       r_shift;
  logic [PCW-1:0]      r_phit_cnt;
  logic                r_link_valid;
  logic                r_link_sow;
  logic                r_overflow;

  logic [DW-1:0]       w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_empty;
  logic                w_last;
  logic                w_accept;
  logic                w_pop;

  // Handshake: a phit transfers on a clock edge where link_valid & link_ready;
  // while valid is high and ready is low, data/sow are held unchanged, and
  // ready seen while valid is low has no effect.
  assign w_last   = (r_phit_cnt == LAST_PHIT);
  assign w_accept = r_link_valid & link_ready;
  assign w_pop    = ~w_empty & ((r_state == ST_IDLE) | (w_accept & w_last));

  link_send_fifo #(
    .DW         (DW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (data_out_wr),
    .i_data  (data_out),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_phit_cnt   <= '0;
      r_link_valid <= 1'b0;
      r_link_sow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift      <= SW'(w_head);
            r_phit_cnt   <= '0;
            r_link_valid <= 1'b1;
            r_link_sow   <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (!w_last) begin
              r_shift    <= r_shift >> PW;
              r_phit_cnt <= r_phit_cnt + 1'b1;
              r_link_sow <= 1'b0;
            end else if (!w_empty) begin
              // Next word loads on the same edge: no idle cycle between words.
              r_shift    <= SW'(w_head);
              r_phit_cnt <= '0;
              r_link_sow <= 1'b1;
            end else begin
              r_shift      <= '0;
              r_phit_cnt   <= '0;
              r_link_valid <= 1'b0;
              r_link_sow   <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (data_out_wr && (w_count == FULL_CNT)) begin
      r_overflow <= 1'b1;
    end
  end

  // Two-entry reserve absorbs the one-cycle lag of the upstream write strobe.
  assign send_fifo_full = (w_count >= FULL_THR);
  assign link_valid     = r_link_valid;
  assign link_data      = r_shift[PW-1:0];
  assign link_sow       = r_link_sow;
  assign overflow_err   = r_overflow;
  assign tx_idle        = (r_state == ST_IDLE) & w_empty;
  assign o_dbg_state    = r_state;
  assign o_dbg_count    = w_count;

endmodule

// File: tb/tb_chip_link_tx.sv
// Self-checking bench for chip_link_tx: directed scenarios plus a randomized
// run, with the phit stream compared against a queue of expected phits.
module tb_chip_link_tx;
  import chip_link_tx_pkg::*;

  localparam int DW         = 60;
  localparam int PW         = 16;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;
  localparam int NPH        = 4;
  localparam logic [DW-1:0] W1 = 60'h0ABC_DEF0_1234_5678;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                data_out_wr;
  logic [DW-1:0]       data_out;
  logic                send_fifo_full;
  logic                link_valid;
  logic [PW-1:0]       link_data;
  logic                link_sow;
  logic                link_ready;
  logic                overflow_err;
  logic                tx_idle;
  tx_state_e           dbg_state;
  logic [DEPTH_LOG2:0] dbg_count;

  chip_link_tx #(.DW(DW), .PW(PW), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_out_wr    (data_out_wr),
    .data_out       (data_out),
    .send_fifo_full (send_fifo_full),
    .link_valid     (link_valid),
    .link_data      (link_data),
    .link_sow       (link_sow),
    .link_ready     (link_ready),
    .overflow_err   (overflow_err),
    .tx_idle        (tx_idle),
    .o_dbg_state    (dbg_state),
    .o_dbg_count    (dbg_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: expected {sow, data} phits and observed transfers
  logic [PW:0] exp_q[$];
  logic [PW:0] obs_q[$];
  int          obs_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n && link_valid && link_ready) begin
      obs_q.push_back({link_sow, link_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] phit_of(input logic [DW-1:0] w, input int k);
    logic [NPH*PW-1:0] p;
    p = {{(NPH*PW-DW){1'b0}}, w};
    return p[k*PW +: PW];
  endfunction

  function automatic void expect_word(input logic [DW-1:0] w);
    for (int k = 0; k < NPH; k++) exp_q.push_back({1'(k == 0), phit_of(w, k)});
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic compare_stream(input string tag, input bit contiguous);
    check($sformatf("%s phit_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s phit%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
      if (contiguous && i > 0)
        check($sformatf("%s gap%0d", tag, i), 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
    end
    clear_q();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!tx_idle && n < 2000) begin
      tick();
      n++;
    end
    check($sformatf("%s drain_timeout", tag), 64'(n < 2000), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    int            model_cnt;
    bit            model_ovf;

    // Reset
    rst_n = 1'b0; data_out_wr = 1'b0; data_out = '0; link_ready = 1'b0;
    #12;
    check("rst valid", 64'(link_valid), 64'd0);
    check("rst sow", 64'(link_sow), 64'd0);
    check("rst data", 64'(link_data), 64'd0);
    check("rst full", 64'(send_fifo_full), 64'd0);
    check("rst ovf", 64'(overflow_err), 64'd0);
    check("rst idle", 64'(tx_idle), 64'd1);
    #10 rst_n = 1'b1;
    tick();

    // Single word, ready high
    clear_q();
    link_ready = 1'b1;
    data_out = W1; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    check("t1 lat valid", 64'(link_valid), 64'd0);
    tick();
    check("t1 p0 valid", 64'(link_valid), 64'd1);
    check("t1 p0 data", 64'(link_data), 64'h5678);
    check("t1 p0 sow", 64'(link_sow), 64'd1);
    tick();
    check("t1 p1 data", 64'(link_data), 64'h1234);
    check("t1 p1 sow", 64'(link_sow), 64'd0);
    tick();
    check("t1 p2 data", 64'(link_data), 64'hDEF0);
    tick();
    check("t1 p3 data", 64'(link_data), 64'h0ABC);
    check("t1 p3 valid", 64'(link_valid), 64'd1);
    tick();
    check("t1 end valid", 64'(link_valid), 64'd0);
    check("t1 end idle", 64'(tx_idle), 64'd1);
    clear_q();

    // Back-pressure during phit 1
    expect_word(W1);
    data_out = W1; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    tick();
    tick();
    check("t2 p1 data", 64'(link_data), 64'h1234);
    link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2 hold%0d data", i), 64'(link_data), 64'h1234);
      check($sformatf("t2 hold%0d valid", i), 64'(link_valid), 64'd1);
    end
    link_ready = 1'b1;
    tick();
    check("t2 p2 data", 64'(link_data), 64'hDEF0);
    wait_idle("t2");
    compare_stream("t2", 1'b0);

    // Back-to-back words
    for (int i = 0; i < 3; i++) begin
      w = rand_word();
      expect_word(w);
      data_out = w; data_out_wr = 1'b1;
      tick();
    end
    data_out_wr = 1'b0;
    wait_idle("t3");
    compare_stream("t3", 1'b1);

    // Full threshold and overflow
    link_ready = 1'b0;
    w = rand_word();
    expect_word(w);
    data_out = w; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    tick();
    check("t4 head loaded count", 64'(dbg_count), 64'd0);
    check("t4 head loaded valid", 64'(link_valid), 64'd1);
    model_cnt = 0;
    model_ovf = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      w = rand_word();
      data_out = w; data_out_wr = 1'b1;
      tick();
      if (model_cnt < DEPTH) begin
        model_cnt++;
        expect_word(w);
      end else begin
        model_ovf = 1'b1;
      end
      check($sformatf("t4 w%0d count", k), 64'(dbg_count), 64'(model_cnt));
      check($sformatf("t4 w%0d full", k), 64'(send_fifo_full), 64'(model_cnt >= DEPTH - 2));
      check($sformatf("t4 w%0d ovf", k), 64'(overflow_err), 64'(model_ovf));
    end
    data_out_wr = 1'b0;
    link_ready = 1'b1;
    wait_idle("t4");
    compare_stream("t4", 1'b1);
    check("t4 ovf sticky", 64'(overflow_err), 64'd1);

    // Reset mid-word, with a second word buffered
    data_out = W1; data_out_wr = 1'b1;
    tick();
    data_out = rand_word();
    tick();
    data_out_wr = 1'b0;
    tick();
    tick();
    check("t5 p2 data", 64'(link_data), 64'hDEF0);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async valid", 64'(link_valid), 64'd0);
    check("t5 rst ovf", 64'(overflow_err), 64'd0);
    check("t5 rst count", 64'(dbg_count), 64'd0);
    #4 rst_n = 1'b1;
    tick();
    check("t5 idle", 64'(tx_idle), 64'd1);
    check("t5 full", 64'(send_fifo_full), 64'd0);
    check("t5 valid", 64'(link_valid), 64'd0);
    clear_q();
    w = rand_word();
    expect_word(w);
    data_out = w; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    tick();
    check("t5 new sow", 64'(link_sow), 64'd1);
    check("t5 new p0", 64'(link_data), 64'(phit_of(w, 0)));
    wait_idle("t5");
    compare_stream("t5", 1'b1);

    // Simultaneous push and pop at count 5
    link_ready = 1'b0;
    w0 = rand_word();
    expect_word(w0);
    data_out = w0; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      w = rand_word();
      if (i == 0) w1 = w;
      expect_word(w);
      data_out = w; data_out_wr = 1'b1;
      tick();
    end
    data_out_wr = 1'b0;
    check("t6 count5", 64'(dbg_count), 64'd5);
    link_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t6 last phit", 64'(link_data), 64'(phit_of(w0, NPH - 1)));
    w = rand_word();
    expect_word(w);
    data_out = w; data_out_wr = 1'b1;
    tick();
    data_out_wr = 1'b0;
    check("t6 pushpop count", 64'(dbg_count), 64'd5);
    check("t6 next sow", 64'(link_sow), 64'd1);
    check("t6 next valid", 64'(link_valid), 64'd1);
    check("t6 next p0", 64'(link_data), 64'(phit_of(w1, 0)));
    wait_idle("t6");
    compare_stream("t6", 1'b1);

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      link_ready = ($urandom_range(0, 3) != 0);
      if (!send_fifo_full && $urandom_range(0, 1) == 1) begin
        w = rand_word();
        expect_word(w);
        data_out = w; data_out_wr = 1'b1;
      end else begin
        data_out_wr = 1'b0;
      end
      tick();
    end
    data_out_wr = 1'b0;
    link_ready = 1'b1;
    tick();
    wait_idle("rand");
    compare_stream("rand", 1'b0);
    check("rand ovf", 64'(overflow_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_link_tx.md
Name: chip_link_tx

Overview:
- Transmit side of the inter-chip link.
- Accepts tagged words (`data_out_wr` / `data_out`) from the chip-connection mux output stage.
- Buffers them in a send FIFO and drives `send_fifo_full` back upstream.
- Serialises each word into PW-bit phits on a narrow off-chip valid/ready link toward the neighbouring chip.

Parameters:
- `DW`, 60, width of one tagged word: flit width 59 + 1 port-select bit.
- `PW`, 16, phit width on the off-chip link.
- `DEPTH_LOG2`, 3, send FIFO depth = 2**DEPTH_LOG2 entries (8).
- `NPHIT`, derived = ceil(DW/PW) (4); localparam, not overridable.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `data_out_wr`  in  1  write strobe from mux output stage
- `data_out`  in  DW  tagged word {sel, flit}
- `send_fifo_full`  out  1  back-pressure to mux output stage
- `link_valid`  out  1  phit valid toward peer chip
- `link_data`  out  PW  phit payload
- `link_sow`  out  1  start-of-word; high on the first phit of each word
- `link_ready`  in  1  peer accepts phit this cycle
- `overflow_err`  out  1  sticky; a write arrived while the FIFO was full
- `tx_idle`  out  1  FIFO empty and no word in flight

Behaviour:
Reset:
- All outputs are 0 on reset, except `tx_idle` = 1.
- FIFO is emptied, FSM goes to IDLE, shift register is cleared.
- Reset asserted mid-word drops the in-flight word and all buffered words.
- `link_valid` falls asynchronously.

FIFO:
- Write when `data_out_wr` = 1.
- Count range 0..DEPTH.
- Simultaneous push and pop leaves the count unchanged.

`send_fifo_full`:
- Combinational: high when count >= DEPTH-2.
- The two-entry reserve covers the upstream registered write strobe, which lags its full sample by one cycle.
- A write when count == DEPTH is dropped and sets `overflow_err`.
- `overflow_err` stays set until reset.

Phit slicing:
- Phit k = word[PW*k +: PW], sent LSB first.
- The last phit is zero-padded above bit DW-1: with defaults, phit 3 bits [15:12] = 0.

FSM state IDLE:
- `link_valid` = 0.
- If the FIFO is non-empty: pop the head into the shift register, set phit_cnt = 0, drive `link_valid` = 1 and `link_sow` = 1 next cycle, go to SEND.
- Pop-to-first-phit latency is 1 cycle.
- Write-to-first-phit latency from an empty FIFO is 2 cycles.

FSM state SEND:
- Outputs are registered and held stable while `link_valid` & ~`link_ready`.
- On `link_ready`, if phit_cnt < NPHIT-1: shift by PW, increment phit_cnt, deassert `link_sow`.
- On `link_ready` with the last phit:
  - FIFO non-empty: pop and load the next word in the same cycle, stay in SEND, assert `link_sow`. There is no bubble between words.
  - FIFO empty: go to IDLE, deassert `link_valid`.

Other rules:
- `link_ready` while `link_valid` = 0 is ignored.
- `tx_idle` = (state == IDLE) & FIFO empty.
- phit_cnt width = max(1, clog2(NPHIT)). It never wraps past NPHIT-1.
- Sustained throughput is 1 word per NPHIT cycles when `link_ready` is held high.

Decomposition:
- Shared package holds:
  - the `clog2` function;
  - the derived `NPHIT` formula;
  - FSM state encodings IDLE = 1'b0, SEND = 1'b1;
  - the link phit field widths, shared with the future `chip_link_rx`.
- One natural sub-module: `link_send_fifo`, a synchronous FIFO with count output, parameterised DW and DEPTH_LOG2.
- The serialiser FSM stays in the top.

Test Plan:
1. Single word, `link_ready` = 1: write 60'h0ABC_DEF0_1234_5678. Required response:
   - 2 cycles later, 4 consecutive phits: 16'h5678, 16'h1234, 16'hDEF0, 16'h0ABC;
   - `link_sow` high on the first phit only;
   - then `link_valid` = 0 and `tx_idle` = 1.
2. Back-pressure: same word, `link_ready` low for 3 cycles during phit 1. Required response: `link_data` = 16'h1234 held stable for those cycles, `link_valid` stays 1, no phit is lost or duplicated.
3. Back-to-back: 3 words written on consecutive cycles, `link_ready` = 1. Required response:
   - 12 phits with no idle cycle between words;
   - `link_sow` on phits 0, 4 and 8.
4. Full threshold: `link_ready` = 0, write 6 words. Required response:
   - `send_fifo_full` = 1 when count reaches 6;
   - 2 further writes are accepted without `overflow_err`;
   - a 9th write is dropped and `overflow_err` = 1 (sticky).
5. Reset mid-word: assert `rst_n` = 0 during phit 2. Required response:
   - `link_valid` = 0 immediately;
   - after release `tx_idle` = 1 and `send_fifo_full` = 0;
   - the next written word starts with `link_sow` = 1 and phit 0.
6. Simultaneous push/pop: with FIFO count = 5, write on the cycle the last phit is accepted. Required response: count stays 5, next word is loaded with no bubble.
